uart_mmio_ctrl: RTL

// - Memory-mapped controller that sequences the existing UART tx/rx cores for the pipelined CPU.
// - Decodes CPU MEM-stage peripheral accesses.
// - Queues TX bytes and feeds the tx core one at a time via a start/busy handshake.
// - Holds the last RX byte, tracks overrun and raises a level IRQ to the CPU.

---
 rtl/uart_ctrl_pkg.sv | 27 ++
 rtl/uart_txq.sv | 61 ++++++
 rtl/uart_mmio_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART MMIO controller.
// Holds the register offsets relative to BASE_ADDR, the CON bit positions,
// the one-hot TX sequencer states and the timeout used while waiting for busy.
package uart_ctrl_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0000_0018;
  localparam logic [31:0] OFF_RXD = 32'h0000_001C;
  localparam logic [31:0] OFF_CON = 32'h0000_0020;

  localparam int CON_TXIE   = 0;
  localparam int CON_RXIE   = 1;
  localparam int CON_RXV    = 2;
  localparam int CON_TXDONE = 3;
  localparam int CON_TXFULL = 4;
  localparam int CON_OVR    = 5;

  // Number of cycles spent in WAIT_HI before giving up on the tx core.
  localparam int TX_TIMEOUT = 16;

  typedef enum logic [3:0] {
    TX_IDLE    = 4'b0001,
    TX_LAUNCH  = 4'b0010,
    TX_WAIT_HI = 4'b0100,
    TX_WAIT_LO = 4'b1000
  } tx_state_e;

endpackage

// File: rtl/uart_txq.sv
// Synchronous FIFO holding bytes waiting for the tx core.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (pointers/count only)
//   push_i, data_i : write request and byte; ignored when full
//   pop_i          : remove head entry; ignored when empty
//   head_o         : current head entry (valid when !empty_o)
//   full_o, empty_o, count_o : occupancy status
module uart_txq #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped controller sequencing the UART tx/rx cores for the CPU.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   addr, rd, wr, wdata : CPU MEM-stage access (word aligned byte address)
//   rdata, hit          : combinational read data and register-match flag
//   irq                 : registered level interrupt
//   tx_data, tx_start   : byte and one-cycle launch pulse to the tx core
//   tx_busy             : tx core is shifting a frame
//   rx_data, rx_valid   : byte and one-cycle strobe from the rx core
module uart_mmio_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          TXQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int CNT_W = $clog2(TXQ_DEPTH) + 1;
  localparam int TMO_W = $clog2(TX_TIMEOUT);

  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd;

  logic             q_full, q_empty, q_pop;
  logic [7:0]       q_head;
  logic [CNT_W-1:0] q_count;
  logic             txfull;

  tx_state_e        state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             txdone_set;

  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rxv_q, rxv_d;
  logic       ovr_set;
  logic       txie_q, txie_d, rxie_q, rxie_d;
  logic       txdone_q, txdone_d, ovr_q, ovr_d;
  logic       irq_q, irq_d;
  logic [31:0] con_rd;
  logic        unused_wdata;

  assign sel_txd = (addr == BASE_ADDR + OFF_TXD);
  assign sel_rxd = (addr == BASE_ADDR + OFF_RXD);
  assign sel_con = (addr == BASE_ADDR + OFF_CON);
  assign hit     = sel_txd | sel_rxd | sel_con;

  assign wr_txd = wr & sel_txd;
  assign wr_con = wr & sel_con;
  assign rd_rxd = rd & sel_rxd;

  // Only the low byte of wdata carries meaning for any register.
  assign unused_wdata = ^wdata[31:8];

  uart_txq #(
    .DEPTH  (TXQ_DEPTH),
    .DATA_W (8)
  ) u_txq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_txd & ~q_full),
    .data_i  (wdata[7:0]),
    .pop_i   (q_pop),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign txfull = (q_count == CNT_W'(TXQ_DEPTH));

  // TX sequencer: pop into tx_data on leaving IDLE so the byte is stable
  // for the whole LAUNCH..WAIT_LO window.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    q_pop      = 1'b0;
    txdone_set = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!q_empty && !tx_busy) begin
          tx_data_d = q_head;
          q_pop     = 1'b1;
          state_d   = TX_LAUNCH;
        end
      end
      TX_LAUNCH: begin
        tmo_d   = '0;
        state_d = TX_WAIT_HI;
      end
      TX_WAIT_HI: begin
        if (tx_busy) begin
          state_d = TX_WAIT_LO;
        end else if (tmo_q == TMO_W'(TX_TIMEOUT - 1)) begin
          // Core never acknowledged the pulse; report completion anyway.
          txdone_set = 1'b1;
          state_d    = TX_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      TX_WAIT_LO: begin
        if (!tx_busy) begin
          txdone_set = 1'b1;
          state_d    = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_start = (state_q == TX_LAUNCH);
  assign tx_data  = tx_data_q;

  // RX holding: a byte arriving while an RXD read drains the buffer
  // replaces it without counting as an overrun.
  always_comb begin
    rx_buf_d = rx_buf_q;
    rxv_d    = rxv_q;
    ovr_set  = 1'b0;
    if (rx_valid) begin
      if (!rxv_q || rd_rxd) begin
        rx_buf_d = rx_data;
        rxv_d    = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rd_rxd) begin
      rxv_d = 1'b0;
    end
  end

  // Set events override a same-cycle write-1-to-clear.
  always_comb begin
    txie_d   = wr_con ? wdata[CON_TXIE] : txie_q;
    rxie_d   = wr_con ? wdata[CON_RXIE] : rxie_q;
    txdone_d = (txdone_q & ~(wr_con & wdata[CON_TXDONE])) | txdone_set;
    ovr_d    = (ovr_q & ~(wr_con & wdata[CON_OVR])) | ovr_set;
    irq_d    = (txie_q & txdone_q) | (rxie_q & rxv_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      tmo_q     <= '0;
      tx_data_q <= '0;
      rx_buf_q  <= '0;
      rxv_q     <= 1'b0;
      txie_q    <= 1'b0;
      rxie_q    <= 1'b0;
      txdone_q  <= 1'b0;
      ovr_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      rx_buf_q  <= rx_buf_d;
      rxv_q     <= rxv_d;
      txie_q    <= txie_d;
      rxie_q    <= rxie_d;
      txdone_q  <= txdone_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    con_rd             = '0;
    con_rd[CON_TXIE]   = txie_q;
    con_rd[CON_RXIE]   = rxie_q;
    con_rd[CON_RXV]    = rxv_q;
    con_rd[CON_TXDONE] = txdone_q;
    con_rd[CON_TXFULL] = txfull;
    con_rd[CON_OVR]    = ovr_q;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd)      rdata = {24'h0, rx_buf_q};
      else if (sel_con) rdata = con_rd;
    end
  end

endmodule
